// File: rtl/sap2_pkg.sv
// Shared SAP-2 definitions: control-word positions for the call/return strobes,
// default program-address sizing and the return-stack operation decode.
package sap2_pkg;

  // The original control word is 30 bits wide; the new strobes extend it upward.
  localparam int unsigned CON_BASE_W = 30;
  localparam int unsigned CALL       = 30;
  localparam int unsigned RET        = 31;
  localparam int unsigned ERR_CLR    = 32;
  localparam int unsigned CON_W      = 33;

  localparam int unsigned DEF_AW    = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    OpNone,
    OpPush,
    OpPop,
    OpSwap,
    OpOvf,
    OpUnf
  } stack_op_e;

  // A call+ret on an empty stack has nothing to swap with, so it degrades to a call.
  function automatic stack_op_e decode_op(input logic call, input logic ret,
                                          input logic full, input logic empty);
    stack_op_e op;
    if (call && ret && !empty) begin
      op = OpSwap;
    end else if (call) begin
      op = full ? OpOvf : OpPush;
    end else if (ret) begin
      op = empty ? OpUnf : OpPop;
    end else begin
      op = OpNone;
    end
    return op;
  endfunction

endpackage

// File: rtl/lifo_regfile.sv
// Return-address storage: one synchronous write port and one combinational read port.
// Pointer management lives in the owner.
module lifo_regfile #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_stack.sv
// Loadable, incrementing program counter backed by a DEPTH-entry return-address stack,
// with sticky overflow/underflow flags and a tristate drive onto the shared bus slice.
module pc_stack
  import sap2_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  inout  wire  [AW-1:0] bus,
  input  logic          lp,
  input  logic          cp,
  input  logic          ep,
  input  logic          call,
  input  logic          ret,
  input  logic          err_clr,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  stack_op_e     op;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] rd_data;
  logic          full_w, empty_w;

  assign full_w  = (depth_q == CW'(DEPTH));
  assign empty_w = (depth_q == '0);
  assign rd_idx  = empty_w ? '0 : IW'(depth_q - CW'(1));
  assign op      = decode_op(call, ret, full_w, empty_w);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    wr_en   = 1'b0;
    wr_idx  = IW'(depth_q);
    unique case (op)
      OpPush: begin
        wr_en   = 1'b1;
        wr_idx  = IW'(depth_q);
        depth_d = depth_q + CW'(1);
        pc_d    = bus;
      end
      OpOvf: begin
        pc_d  = bus;
        ovf_d = 1'b1;
      end
      OpSwap: begin
        wr_en  = 1'b1;
        wr_idx = rd_idx;
        pc_d   = bus;
      end
      OpPop: begin
        pc_d    = rd_data;
        depth_d = depth_q - CW'(1);
      end
      OpUnf: begin
        unf_d = 1'b1;
      end
      default: begin
        if (lp) begin
          pc_d = bus;
        end else if (cp) begin
          pc_d = pc_q + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  lifo_regfile #(
    .AW   (AW),
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_lifo (
    .clk  (clk),
    .clr  (clr),
    .we   (wr_en),
    .waddr(wr_idx),
    .wdata(pc_q),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  // Never drive the bus in a cycle where it is being sampled.
  assign bus = (ep && !lp && !call) ? pc_q : 'z;

  assign pc    = pc_q;
  assign depth = depth_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program-address unit for the SAP-2 family: a loadable, incrementing program counter backed by a `DEPTH`-entry return-address stack. It supports nested subroutine calls, where the previous generation allowed only one level. It sits on the low `AW` bits of the shared bus, in the same position as the single program counter / subroutine counter pair. It is driven by the control unit's fetch and jump strobes plus dedicated call/return strobes.

## Interface
- `AW`, 8, address width (PC, stack entries, bus slice).
- `DEPTH`, 4, return-stack entries; must be ≥ 2.
- `CW`, `$clog2(DEPTH+1)`, width of the occupancy count.

- `clk` in 1: single clock. All state updates on its rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `bus` inout AW: shared bus slice. Loads are taken from here; PC is driven here when enabled, otherwise `z`.
- `lp` in 1: load PC from `bus`.
- `cp` in 1: increment PC.
- `ep` in 1: enable PC onto `bus`.
- `call` in 1: push PC, then load PC from `bus`.
- `ret` in 1: pop top of stack into PC.
- `err_clr` in 1: clear the sticky error flags.
- `pc` out AW: current PC value, always visible.
- `depth` out CW: number of valid stack entries.
- `full` out 1: `depth == DEPTH`.
- `empty` out 1: `depth == 0`.
- `ovf` out 1: sticky, set by a call on a full stack.
- `unf` out 1: sticky, set by a return on an empty stack.

## Operation
- Per-cycle priority: `clr` > (`call`/`ret`) > `lp` > `cp`. At most one PC update per cycle.
- **call only**
  - Not full: `stack[depth] <= pc`, `depth <= depth+1`, `pc <= bus`.
  - Full: `pc <= bus`, stack and `depth` unchanged, `ovf <= 1`. The return address is lost and the existing entries are preserved.
- **ret only**
  - Not empty: `pc <= stack[depth-1]`, `depth <= depth-1`.
  - Empty: `pc` unchanged, `unf <= 1`.
- **call and ret together (swap/coroutine)**
  - Not empty: `stack[depth-1] <= pc`, `pc <= bus`, `depth` unchanged.
  - Empty: behaves as call only.
- **lp**: `pc <= bus`.
- **cp**: `pc <= pc + 1`, modulo 2^AW (`{AW{1}}` wraps to 0, no flag).
- `err_clr` clears `ovf`/`unf`. If a new error event occurs in the same cycle, the set wins.
- Bus drive: `bus = pc` when `ep & ~lp & ~call`, else `z`. The block never drives the bus in a cycle where it samples it.
- `full`, `empty`, `ovf`, `unf` are ignored for `lp`/`cp`. Only call/ret touch the stack.

## Timing
- Reset (`clr` high at a rising edge) sets: `pc=0`, `depth=0`, `full=0`, `empty=1`, `ovf=0`, `unf=0`, all stack entries 0. Reset overrides every other input in the same cycle. A call or return in progress is simply discarded.
- All outputs except `bus` are registered. Updates are visible one cycle after the strobe edge, and the latency is 1 cycle for every operation.
- `bus` drive is combinational from `ep`/`lp`/`call` and the registered `pc`.
- `full`/`empty` are derived from registered `depth` with no extra delay.
- Back-to-back call/ret on consecutive cycles is supported at full rate, with no bubbles.
- Strobes are level-sampled at each rising edge. Holding `call` for N cycles performs N pushes.

## Structure
- A shared package `sap2_pkg` holds:
  - the control-word bit positions for the new strobes (`CALL`, `RET`, `ERR_CLR`), extending the existing 30-bit con map;
  - the default `AW`/`DEPTH` localparams.
- There is one natural sub-module, `lifo_regfile`:
  - `DEPTH` × `AW` storage with one write port (index, data, enable) and a combinational read of index `depth-1`;
  - pointer and flag logic stay in `pc_stack`.
- The `bus` tristate is inside `pc_stack`. The top level only connects `bus[AW-1:0]`.

## Test plan
- Reset then increment: assert `clr`, then 3 cycles of `cp` -> `pc=3`, `depth=0`, `empty=1`. With `AW=8`, `lp` on `bus=8'hFF` then `cp` -> `pc=8'h00`, no flag.
- Nested call/return: `pc=8'h10`; call with `bus=8'h40`, call with `bus=8'h80` -> `pc=8'h80`, `depth=2`. Then ret, ret -> `pc=8'h40`, then `8'h10`, `empty=1`.
- Overflow, `DEPTH=4`: 5 calls with `bus` = 1, 2, 3, 4, 5 from `pc=0` -> `pc=5`, `depth=4`, `full=1`, `ovf=1`. Then 4 rets -> `pc` = 3, 2, 1, 0. A 5th ret -> `pc` unchanged at 0, `unf=1`.
- Swap: `depth=1`, `stack[0]=8'h22`, `pc=8'h30`; call+ret with `bus=8'h50` -> `pc=8'h50`, `stack[0]=8'h30`, `depth=1`.
- Bus and priority: `ep=1` with no load -> `bus=pc`. `ep=1` with `lp=1` -> block drives `z` and loads `bus`. `lp=1` and `cp=1` together -> `pc=bus`, not `bus+1`.
- Reset and flag clear:
  - `clr` mid-sequence with `depth=3` and `ovf=1` -> next cycle all reset values.
  - Separately, `err_clr` with a simultaneous empty ret -> `unf` stays 1.
